// File: rtl/prm_edge_chk_seq.sv
// prm_edge_chk_seq: programmable sum-of-products edge checker, one stored term per clock.
// Define PRM_EDGE_CHK_EARLY_EXIT_EN to end the scan as soon as every edge is blocked.
module prm_edge_chk_seq #(
    parameter int IN_W = 15,
    parameter int EDGES = 16,
    parameter int TERM_DEPTH = 256,
    localparam int EID_W = $clog2(EDGES),
    localparam int AW = $clog2(TERM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [IN_W-1:0]  cfg_care,
    input  logic [IN_W-1:0]  cfg_val,
    input  logic [EID_W-1:0] cfg_eid,
    input  logic             cfg_len_we,
    input  logic [AW:0]      cfg_len,
    output logic             cfg_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_occ,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EDGES-1:0] out_mask
);
    localparam int TW = 2 * IN_W + EID_W;
    localparam logic [AW:0] DEPTH = (AW + 1)'(TERM_DEPTH);
`ifdef PRM_EDGE_CHK_EARLY_EXIT_EN
    localparam logic EARLY = 1'b1;
`else
    localparam logic EARLY = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t           state_q;
    logic [TW-1:0]    mem [TERM_DEPTH];
    logic [TW-1:0]    rd_q;
    logic [IN_W-1:0]  occ_q, rd_care, rd_val;
    logic [EID_W-1:0] rd_eid;
    logic [EDGES-1:0] mask_q, mask_d;
    logic [AW:0]      len_q, len_d, ptr_q;
    logic             rv_q, idle, hit, more, last;
    assign idle = state_q == IDLE;
    assign {rd_care, rd_val, rd_eid} = rd_q;
    // rv_q marks that rd_q holds a term read in the previous cycle
    always_comb begin
        hit = rv_q && ((occ_q ^ rd_val) & rd_care) == '0 && int'(rd_eid) < EDGES;
        mask_d = hit ? mask_q | (EDGES'(1) << rd_eid) : mask_q;
        more = ptr_q < len_q;
        last = rv_q && (!more || (EARLY && &mask_d));
        len_d = cfg_len > DEPTH ? DEPTH : cfg_len;
    end
    always_ff @(posedge clk) begin
        if (cfg_we && idle) mem[cfg_addr] <= {cfg_care, cfg_val, cfg_eid};
        rd_q <= mem[ptr_q[AW-1:0]];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            occ_q <= '0;
            mask_q <= '0;
            len_q <= '0;
            ptr_q <= '0;
            rv_q <= 1'b0;
        end else begin
            if (cfg_len_we && idle) len_q <= len_d;
            case (state_q)
                IDLE: if (in_valid) begin
                    occ_q <= in_occ;
                    mask_q <= '0;
                    ptr_q <= '0;
                    state_q <= len_q != '0 ? SCAN : DONE;
                end
                SCAN: begin
                    mask_q <= mask_d;
                    rv_q <= more && !last;
                    ptr_q <= ptr_q + (AW + 1)'(more && !last);
                    if (last) state_q <= DONE;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign cfg_ready = idle;
    assign in_ready = idle;
    assign out_valid = state_q == DONE;
    assign out_mask = mask_q;
endmodule

// File: tb/tb_prm_edge_chk_seq.sv
// tb_prm_edge_chk_seq: randomized bench with a term-list reference model checked every cycle.
module tb_prm_edge_chk_seq;
    localparam int IN_W = 15, EDGES = 16, DEPTH = 256, AW = 8;
    logic clk = 0, rst = 1, cfg_we = 0, cfg_len_we = 0, in_valid = 0, out_ready = 0;
    logic [AW-1:0] cfg_addr = '0;
    logic [IN_W-1:0] cfg_care = '0, cfg_val = '0, in_occ = '0;
    logic [3:0] cfg_eid = '0;
    logic [AW:0] cfg_len = '0;
    logic cfg_ready, in_ready, out_valid;
    logic [EDGES-1:0] out_mask;
    int total = 0, bad = 0, cyc = 0;
    logic [IN_W-1:0] m_care [DEPTH], m_val [DEPTH];
    int m_eid [DEPTH];
    int m_len = 0, a_cyc = 0, e_lat = 0;
    logic pending = 0, clean = 1;
    logic [15:0] e_mask = '0;

    prm_edge_chk_seq dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care),
        .cfg_val(cfg_val), .cfg_eid(cfg_eid), .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
        .cfg_ready(cfg_ready), .in_valid(in_valid), .in_ready(in_ready), .in_occ(in_occ),
        .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Result and latency straight from the term list: every term scanned in order.
    function automatic void model_run(input logic [IN_W-1:0] occ, output logic [15:0] m, output int lat);
`ifdef PRM_EDGE_CHK_EARLY_EXIT_EN
        bit full = 0;
`endif
        m = '0;
        lat = m_len == 0 ? 1 : m_len + 2;
        for (int i = 0; i < m_len; i++) begin
            if (((occ ^ m_val[i]) & m_care[i]) == '0) m[m_eid[i]] = 1'b1;
`ifdef PRM_EDGE_CHK_EARLY_EXIT_EN
            if (&m && !full) begin
                full = 1;
                lat = i + 3;
            end
`endif
        end
    endfunction

    always @(posedge clk) begin
        logic idle_m, hs;
        cyc++;
        if (rst) begin
            pending = 0;
            clean = 1;
            m_len = 0;
        end else begin
            idle_m = !pending;
            hs = pending && cyc >= a_cyc + e_lat && out_ready;
            if (idle_m && cfg_we) begin
                m_care[cfg_addr] = cfg_care;
                m_val[cfg_addr] = cfg_val;
                m_eid[cfg_addr] = int'(cfg_eid);
            end
            if (idle_m && in_valid) begin
                model_run(in_occ, e_mask, e_lat);
                a_cyc = cyc;
                pending = 1;
                clean = 0;
            end
            if (idle_m && cfg_len_we) m_len = cfg_len > 9'd256 ? 256 : int'(cfg_len);
            if (hs) pending = 0;
        end
    end

    always @(negedge clk) begin
        logic ov;
        if (rst) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_in_ready", 32'(in_ready), 1);
            chk("rst_out_mask", 32'(out_mask), 0);
        end else begin
            ov = pending && cyc >= a_cyc + e_lat - 1;
            chk("out_valid", 32'(out_valid), 32'(ov));
            chk("in_ready", 32'(in_ready), 32'(!pending));
            chk("cfg_ready", 32'(cfg_ready), 32'(!pending));
            if (ov || clean) chk("out_mask", 32'(out_mask), 32'(ov ? e_mask : 16'h0));
        end
    end

    task automatic write_term(input int addr, input logic [IN_W-1:0] care, input logic [IN_W-1:0] val, input int eid);
        cfg_we = 1;
        cfg_addr = AW'(addr);
        cfg_care = care;
        cfg_val = val;
        cfg_eid = 4'(eid);
        @(posedge clk);
        #1 cfg_we = 0;
    endtask

    task automatic set_len(input int len);
        cfg_len_we = 1;
        cfg_len = 9'(len);
        @(posedge clk);
        #1 cfg_len_we = 0;
    endtask

    task automatic send(input logic [IN_W-1:0] occ, input int hold, input bit hold_iv,
                        output logic [15:0] m, output int lat);
        int c0, n;
        in_valid = 1;
        in_occ = occ;
        @(posedge clk);
        #1 in_valid = 0;
        c0 = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 600);
        if (!out_valid) chk("send_timeout", 32'(out_valid), 1);
        lat = cyc - c0 + 1;
        m = out_mask;
        if (hold_iv) in_valid = 1;
        repeat (hold) @(negedge clk);
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m, e;
        logic [IN_W-1:0] occ;
        int lat, dl;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_cfg_ready", 32'(cfg_ready), 1);
        chk("reset_out_mask", 32'(out_mask), 0);
        write_term(0, 15'h7FFF, 15'h1234, 3);
        set_len(1);
        send(15'h1234, 0, 0, m, lat);
        chk("t0_hit_mask", 32'(m), 32'h0008);
        chk("t0_hit_lat", 32'(lat), 3);
        send(15'h1235, 0, 0, m, lat);
        chk("t0_miss_mask", 32'(m), 0);
        chk("t0_miss_lat", 32'(lat), 3);
        set_len(0);
        send(15'h5A5A, 0, 0, m, lat);
        chk("l0_mask", 32'(m), 0);
        chk("l0_lat", 32'(lat), 1);
        for (int i = 0; i < DEPTH; i++) write_term(i, 15'h0, 15'($urandom), i % 16);
        set_len(256);
        send(15'($urandom), 10, 1, m, lat);
        chk("full_mask", 32'(m), 32'hFFFF);
`ifdef PRM_EDGE_CHK_EARLY_EXIT_EN
        chk("full_lat", 32'(lat), 18);
`else
        chk("full_lat", 32'(lat), 258);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            int eid = $urandom_range(0, 14);
            write_term(i, 15'($urandom) & 15'($urandom), 15'($urandom), eid >= 5 ? eid + 1 : eid);
        end
        set_len(20);
        occ = m_val[0];
        model_run(occ, e, dl);
        send(occ, 0, 0, m, lat);
        chk("pre_drop_mask", 32'(m), 32'(e));
        fork
            send(occ, 0, 0, m, lat);
            begin
                repeat (4) @(posedge clk);
                #1 write_term(0, 15'h0, 15'h0, 5);
            end
        join
        chk("cfg_drop_mask", 32'(m), 32'(e));
        chk("cfg_drop_bit5", 32'(m[5]), 0);
        set_len(100);
        in_valid = 1;
        in_occ = m_val[1];
        @(posedge clk);
        #1 in_valid = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        #1 chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_mask", 32'(out_mask), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 rst = 0;
        set_len(100);
        occ = m_val[2];
        model_run(occ, e, dl);
        send(occ, 1, 1, m, lat);
        chk("post_rst_mask", 32'(m), 32'(e));
        chk("post_rst_lat", 32'(lat), 32'(dl));
        repeat (40) begin
            if ($urandom_range(0, 3) == 0)
                repeat (8) write_term($urandom_range(0, 40), 15'($urandom) & 15'($urandom), 15'($urandom), $urandom_range(0, 15));
            set_len($urandom_range(0, 40));
            occ = m_val[$urandom_range(0, 7)] ^ ($urandom_range(0, 3) == 0 ? 15'($urandom) : 15'h0);
            fork
                send(occ, $urandom_range(0, 3), 1'($urandom_range(0, 1)), m, lat);
                begin
                    repeat ($urandom_range(0, 5)) begin
                        @(posedge clk);
                        #1 cfg_we = 1'($urandom_range(0, 1));
                        cfg_len_we = 1'($urandom_range(0, 1));
                        cfg_addr = AW'($urandom);
                        cfg_care = 15'($urandom);
                        cfg_val = 15'($urandom);
                        cfg_eid = 4'($urandom);
                        cfg_len = 9'($urandom_range(0, 300));
                    end
                    @(posedge clk);
                    #1 cfg_we = 0;
                    cfg_len_we = 0;
                end
            join
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
